// File: rtl/disp_timing_gen.sv
// Display timing generator: derives HS/VS/DE from per-instance timings and issues pixel
// requests REQ_LAT+1 clocks ahead of DE, so the pixel source stays aligned with the panel.
module disp_timing_gen #(
   parameter int   H_SYNC  = 96,
   parameter int   H_BP    = 48,
   parameter int   H_ACT   = 640,
   parameter int   H_FP    = 16,
   parameter int   V_SYNC  = 2,
   parameter int   V_BP    = 33,
   parameter int   V_ACT   = 480,
   parameter int   V_FP    = 10,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   R_W     = 5,
   parameter int   G_W     = 6,
   parameter int   B_W     = 5,
   parameter int   REQ_LAT = 1
) (
   input  logic                   ClkDisp,
   input  logic                   Rst_n,
   input  logic                   En,
   input  logic [R_W+G_W+B_W-1:0] Data,
   output logic                   DataReq,
   output logic [11:0]            H_Addr,
   output logic [11:0]            V_Addr,
   output logic                   Disp_HS,
   output logic                   Disp_VS,
   output logic                   Disp_DE,
   output logic [R_W-1:0]         Disp_Red,
   output logic [G_W-1:0]         Disp_Green,
   output logic [B_W-1:0]         Disp_Blue,
   output logic                   frame_begin,
   output logic                   Running,
   output logic                   Disp_PCLK
);

   localparam int PIX_W = R_W + G_W + B_W;
   localparam int HT    = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int VT    = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int DLY   = REQ_LAT + 2;

   localparam logic [11:0] HT_M1  = 12'(HT - 1);
   localparam logic [11:0] VT_M1  = 12'(VT - 1);
   localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
   localparam logic [11:0] V_SYNC_C = 12'(V_SYNC);
   localparam logic [11:0] H_AS   = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_AE   = 12'(H_SYNC + H_BP + H_ACT);
   localparam logic [11:0] V_AS   = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_AE   = 12'(V_SYNC + V_BP + V_ACT);

   generate
      if (REQ_LAT < 0 || REQ_LAT > 15) begin : g_bad_lat
         $error("disp_timing_gen: REQ_LAT must be within 0..15");
      end
      if (HT >= 4096 || VT >= 4096) begin : g_bad_sum
         $error("disp_timing_gen: horizontal/vertical totals must be below 4096");
      end
   endgenerate

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [11:0]      hcnt_q, hcnt_d;
   logic [11:0]      vcnt_q, vcnt_d;
   logic             last_pix;
   logic             active;
   logic             hs0, vs0, de0, fb0;
   logic             datareq_q;
   logic [11:0]      h_addr_q, v_addr_q;
   logic [DLY-1:0]   hs_sr_q, vs_sr_q, de_sr_q, fb_sr_q;
   logic [PIX_W-1:0] rgb_q;

   assign last_pix = (hcnt_q == HT_M1) && (vcnt_q == VT_M1);

   always_ff @(posedge ClkDisp or negedge Rst_n) begin
      if (!Rst_n) state_q <= ST_STOP;
      else        state_q <= state_d;
   end

   // Leaving RUN/DRAIN is only allowed at the last pixel, so a frame is never cut short.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP:  if (En) state_d = ST_RUN;
         ST_RUN:   if (!En) state_d = last_pix ? ST_STOP : ST_DRAIN;
         ST_DRAIN: begin
            if (En)            state_d = ST_RUN;
            else if (last_pix) state_d = ST_STOP;
         end
         default:  state_d = ST_STOP;
      endcase
   end

   always_comb begin
      active  = (state_q != ST_STOP);
      Running = active;
   end

   always_comb begin
      hcnt_d = hcnt_q + 12'd1;
      vcnt_d = vcnt_q;
      if (!active) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (hcnt_q == HT_M1) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == VT_M1) ? 12'd0 : vcnt_q + 12'd1;
      end
   end

   always_ff @(posedge ClkDisp or negedge Rst_n) begin
      if (!Rst_n) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   always_comb begin
      hs0 = active && (hcnt_q < H_SYNC_C);
      vs0 = active && (vcnt_q < V_SYNC_C);
      de0 = active && (hcnt_q >= H_AS) && (hcnt_q < H_AE) && (vcnt_q >= V_AS) && (vcnt_q < V_AE);
      fb0 = active && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
   end

   // Sync/DE/frame_begin ride a DLY-deep delay line; RGB is captured on its last-but-one tap.
   always_ff @(posedge ClkDisp or negedge Rst_n) begin
      if (!Rst_n) begin
         datareq_q <= 1'b0;
         h_addr_q  <= '0;
         v_addr_q  <= '0;
         hs_sr_q   <= '0;
         vs_sr_q   <= '0;
         de_sr_q   <= '0;
         fb_sr_q   <= '0;
         rgb_q     <= '0;
      end else begin
         datareq_q <= de0;
         h_addr_q  <= de0 ? hcnt_q - H_AS : 12'd0;
         v_addr_q  <= de0 ? vcnt_q - V_AS : 12'd0;
         hs_sr_q   <= {hs_sr_q[DLY-2:0], hs0};
         vs_sr_q   <= {vs_sr_q[DLY-2:0], vs0};
         de_sr_q   <= {de_sr_q[DLY-2:0], de0};
         fb_sr_q   <= {fb_sr_q[DLY-2:0], fb0};
         rgb_q     <= de_sr_q[DLY-2] ? Data : '0;
      end
   end

   assign DataReq     = datareq_q;
   assign H_Addr      = h_addr_q;
   assign V_Addr      = v_addr_q;
   assign Disp_HS     = HS_POL ? hs_sr_q[DLY-1] : ~hs_sr_q[DLY-1];
   assign Disp_VS     = VS_POL ? vs_sr_q[DLY-1] : ~vs_sr_q[DLY-1];
   assign Disp_DE     = de_sr_q[DLY-1];
   assign frame_begin = fb_sr_q[DLY-1];
   assign Disp_Red    = rgb_q[PIX_W-1 -: R_W];
   assign Disp_Green  = rgb_q[B_W +: G_W];
   assign Disp_Blue   = rgb_q[B_W-1:0];
   assign Disp_PCLK   = ClkDisp;

endmodule
